// File: rtl/uart_rx_8e1.sv
// uart_rx_8e1 -- UART receiver, 8 data bits LSB first, even parity, 1 stop bit.
//
// Recovers bytes from an asynchronous serial line and presents each good byte
// as a 1-cycle data_valid strobe with data_out holding the byte. Parity and
// framing problems are reported as separate 1-cycle pulses and the byte is
// dropped (data_out keeps the last good byte).
//
// Parameters
//   CLKS_PER_BIT  sysclk cycles per UART bit (>= 8)
//   SYNC_STAGES   flops in the rxd synchronizer (>= 2)
//
// Ports
//   sysclk      in   system clock
//   rst         in   synchronous reset, active-high
//   rxd_in      in   asynchronous serial input, idles high
//   data_out    out  [7:0] last good byte received
//   data_valid  out  1-cycle pulse, new good byte on data_out
//   parity_err  out  1-cycle pulse, byte dropped on parity mismatch
//   frame_err   out  1-cycle pulse, stop bit sampled low, byte dropped
//   busy        out  high whenever the receiver is not idle
//
// Build option
//   UART_RX_MAJORITY_EN  when defined, every bit sample is the 2-of-3 majority
//                        of rx_s at ticks MID-1, MID, MID+1 (decision at MID+1),
//                        which delays every event by one cycle.

module uart_rx_8e1 #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       rxd_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW  = $clog2(CLKS_PER_BIT);
    localparam int MID = CLKS_PER_BIT / 2 - 1;

`ifdef UART_RX_MAJORITY_EN
    localparam int START_TICK = MID + 1;
`else
    localparam int START_TICK = MID;
`endif

    localparam logic [TW-1:0] START_T = TW'(START_TICK);
    localparam logic [TW-1:0] LAST_T  = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer. Loads 1s on reset (idle line level). flush marks
    // which stages already hold post-reset samples, so the reset-time 1s
    // are never mistaken for the line having been seen high.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES-1:0] flush;
    logic                   rx_s;
    logic                   armed;

    assign rx_s = sync[SYNC_STAGES-1];

    always_ff @(posedge sysclk) begin
        if (rst) begin
            sync  <= '1;
            flush <= '0;
            armed <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], rxd_in};
            flush <= {flush[SYNC_STAGES-2:0], 1'b1};
            // Only a genuinely observed high level arms start detection.
            if (flush[SYNC_STAGES-1] && rx_s)
                armed <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Bit sample. All decisions happen on the edge where tick_cnt equals the
    // decision tick; samp is the line value to use on that edge.
    // ------------------------------------------------------------------
    logic samp;

`ifdef UART_RX_MAJORITY_EN
    // hist[0] is rx_s one cycle ago, hist[1] two cycles ago, so together with
    // the current rx_s they cover the three ticks ending at the decision tick.
    logic [1:0] hist;

    always_ff @(posedge sysclk) begin
        if (rst)
            hist <= 2'b11;
        else
            hist <= {hist[0], rx_s};
    end

    assign samp = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign samp = rx_s;
`endif

    // ------------------------------------------------------------------
    // FSM and datapath
    // ------------------------------------------------------------------
    state_t          state, state_nxt;
    logic [TW-1:0]   tick_cnt, tick_nxt;
    logic [2:0]      bit_cnt, bit_nxt;
    logic [7:0]      shreg, shreg_nxt;
    logic            perr, perr_nxt;
    logic [7:0]      data_nxt;
    logic            dv_nxt, pe_nxt, fe_nxt;
    logic            tick_last;

    assign tick_last = (tick_cnt == LAST_T);

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            perr       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            tick_cnt   <= tick_nxt;
            bit_cnt    <= bit_nxt;
            shreg      <= shreg_nxt;
            perr       <= perr_nxt;
            data_out   <= data_nxt;
            data_valid <= dv_nxt;
            parity_err <= pe_nxt;
            frame_err  <= fe_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt + 1'b1;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        perr_nxt  = perr;
        data_nxt  = data_out;
        dv_nxt    = 1'b0;
        pe_nxt    = 1'b0;
        fe_nxt    = 1'b0;

        unique case (state)
            S_IDLE: begin
                tick_nxt = '0;
                if (!rx_s && armed)
                    state_nxt = S_START;
            end

            // Re-check the start bit half a bit in; from here on the tick
            // grid is aligned so that tick LAST_T is the middle of each bit.
            S_START: begin
                if (tick_cnt == START_T) begin
                    tick_nxt = '0;
                    if (samp) begin
                        state_nxt = S_IDLE;
                    end else begin
                        bit_nxt   = '0;
                        state_nxt = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (tick_last) begin
                    tick_nxt  = '0;
                    shreg_nxt = {samp, shreg[7:1]};
                    bit_nxt   = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7)
                        state_nxt = S_PARITY;
                end
            end

            S_PARITY: begin
                if (tick_last) begin
                    tick_nxt  = '0;
                    perr_nxt  = samp ^ (^shreg);
                    state_nxt = S_STOP;
                end
            end

            // Decision is made mid stop bit, so IDLE is reached half a bit
            // early and a start edge right after the stop bit is caught.
            S_STOP: begin
                if (tick_last) begin
                    tick_nxt = '0;
                    if (!samp) begin
                        fe_nxt    = 1'b1;
                        state_nxt = S_BREAK;
                    end else if (perr) begin
                        pe_nxt    = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        data_nxt  = shreg;
                        dv_nxt    = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end

            // Line held low past the stop bit: wait for it to return high.
            S_BREAK: begin
                tick_nxt = '0;
                if (rx_s)
                    state_nxt = S_IDLE;
            end

            default: begin
                tick_nxt  = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_8e1.sv
// Directed bench for uart_rx_8e1 with a scoreboard of expected pulses.
// The DUT runs with a short bit time so the whole run stays small.

module tb_uart_rx_8e1;

    localparam int CPB  = 32;
    localparam int SYNC = 2;
    localparam int MID  = CPB / 2 - 1;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = SYNC + MID + 10 * CPB + 1 + 1;
`else
    localparam int LAT = SYNC + MID + 10 * CPB + 1;
`endif

    logic       sysclk = 1'b0;
    logic       rst;
    logic       rxd_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    uart_rx_8e1 #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .rxd_in     (rxd_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 sysclk = ~sysclk;

    // kind: 0 = data_valid, 1 = parity_err, 2 = frame_err
    typedef struct {
        logic [1:0] kind;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         fall_cyc = 0;
    int         last_dv_cyc = 0;
    int         pulse_cnt = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every output pulse is checked against the scoreboard head.
    always @(negedge sysclk) begin
        int   n;
        logic [1:0] k;
        exp_t e;
        if (data_valid || parity_err || frame_err) begin
            pulse_cnt++;
            n = int'(data_valid) + int'(parity_err) + int'(frame_err);
            k = frame_err ? 2'd2 : (parity_err ? 2'd1 : 2'd0);
            chk("single_pulse", n, 1);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'd0, k}, 32'd3);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", {30'd0, k}, {30'd0, e.kind});
                if (e.kind == 2'd0) begin
                    chk("data_out", {24'd0, data_out}, {24'd0, e.data});
                    last_good   = e.data;
                    last_dv_cyc = cyc;
                end else begin
                    chk("data_held", {24'd0, data_out}, {24'd0, last_good});
                end
            end
        end
    end

    task automatic idle(input int n);
        rxd_in = 1'b1;
        repeat (n) @(negedge sysclk);
    endtask

    // Drives one frame; the line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        exp_t e;
        e.data = d;
        if (!stp)               e.kind = 2'd2;
        else if (par != ^d)     e.kind = 2'd1;
        else                    e.kind = 2'd0;
        sb.push_back(e);
        @(negedge sysclk);
        rxd_in   = 1'b0;
        fall_cyc = cyc;
        repeat (CPB) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
            rxd_in = d[i];
            repeat (CPB) @(negedge sysclk);
        end
        rxd_in = par;
        repeat (CPB) @(negedge sysclk);
        rxd_in = stp;
        repeat (CPB) @(negedge sysclk);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_frame(d, ^d, 1'b1);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge sysclk);
            n++;
        end
        repeat (2) @(negedge sysclk);
        chk(tag, sb.size(), 0);
    endtask

    initial begin
        int p0;
        rst    = 1'b1;
        rxd_in = 1'b1;
        repeat (5) @(negedge sysclk);

        // Reset state
        chk("rst_data_out",   {24'd0, data_out}, 32'h00);
        chk("rst_data_valid", {31'd0, data_valid}, 0);
        chk("rst_parity_err", {31'd0, parity_err}, 0);
        chk("rst_frame_err",  {31'd0, frame_err}, 0);
        chk("rst_busy",       {31'd0, busy}, 0);
        rst = 1'b0;
        idle(2 * CPB);

        // T1: good byte, latency counted from the first edge that sees the low line
        send_byte(8'h16);
        idle(2 * CPB);
        wait_drain("t1_drain", 20 * CPB);
        chk("t1_latency", last_dv_cyc - fall_cyc - 1, LAT);
        chk("t1_data", {24'd0, data_out}, 32'h16);

        // T2: wrong parity
        send_frame(8'h38, 1'b0, 1'b1);
        idle(2 * CPB);
        wait_drain("t2_drain", 20 * CPB);
        chk("t2_data_kept", {24'd0, data_out}, 32'h16);

        // T3: framing error, break, recovery
        send_frame(8'h00, 1'b0, 1'b0);
        rxd_in = 1'b0;
        repeat (3 * CPB) @(negedge sysclk);
        chk("t3_busy_in_break", {31'd0, busy}, 1);
        idle(2 * CPB);
        wait_drain("t3_fe_drain", 20 * CPB);
        chk("t3_idle_after_break", {31'd0, busy}, 0);
        send_byte(8'hFF);
        idle(2 * CPB);
        wait_drain("t3_ff_drain", 20 * CPB);
        chk("t3_data_ff", {24'd0, data_out}, 32'hFF);

        // T4: short low glitch is a false start
        p0 = pulse_cnt;
        @(negedge sysclk);
        rxd_in = 1'b0;
        repeat (10) @(negedge sysclk);
        chk("t4_busy_on_glitch", {31'd0, busy}, 1);
        rxd_in = 1'b1;
        repeat (12) @(negedge sysclk);
        chk("t4_busy_released", {31'd0, busy}, 0);
        idle(4 * CPB);
        chk("t4_no_pulse", pulse_cnt, p0);

        // T5: 50 bytes, 100-cycle gaps
        for (int i = 0; i < 50; i++) begin
            logic [7:0] b;
            b = 8'h16 + 8'(i * 8'h22);
            send_byte(b);
            idle(100);
        end
        wait_drain("t5_drain", 20 * CPB);
        chk("t5_last_byte", {24'd0, data_out}, {24'd0, 8'(8'h16 + 8'(49 * 8'h22))});

        // T6: reset in the middle of 0xA5 with the line low
        @(negedge sysclk);
        rxd_in = 1'b0;                       // start
        repeat (CPB) @(negedge sysclk);
        rxd_in = 1'b1;                       // bit0 = 1
        repeat (CPB) @(negedge sysclk);
        rxd_in = 1'b0;                       // bit1 = 0
        repeat (CPB / 2) @(negedge sysclk);
        chk("t6_busy_before_rst", {31'd0, busy}, 1);
        rst = 1'b1;
        repeat (3) @(negedge sysclk);
        chk("t6_rst_data_out", {24'd0, data_out}, 32'h00);
        chk("t6_rst_busy", {31'd0, busy}, 0);
        chk("t6_rst_pulses", {29'd0, data_valid, parity_err, frame_err}, 0);
        rst       = 1'b0;
        last_good = 8'h00;
        repeat (3 * CPB) @(negedge sysclk);
        chk("t6_no_start_while_low", {31'd0, busy}, 0);
        idle(2 * CPB);
        send_byte(8'h5A);
        idle(2 * CPB);
        wait_drain("t6_drain", 20 * CPB);
        chk("t6_data_5a", {24'd0, data_out}, 32'h5A);

        chk("total_pulses", pulse_cnt, 55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
